uart_packet_rx: RTL
===================

# uart_packet_rx

Receive-side counterpart of the radar's UART packet transmitter: accepts command packets from the host plotting tool on a 2-FF-synchronised RX pin and validates framing and checksum. Decoded commands are exposed as registered control values (trigger-distance choice, manual servo angle, remote manual request) and a one-cycle command strobe. Sits beside the transmitter in the top level, on the spare GPIO RX pin, clocked from the 50 MHz system clock.

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- BAUD, 115_200: line rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (434).
- TIMEOUT_BITS, 40: inter-byte timeout in bit times, measured while a packet is partially received.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- uart_rx_pin  in  1  serial input; idle high, 8N1, LSB first.
- cmd_valid  out  1  one-cycle pulse per accepted packet.
- cmd_id  out  8  command byte of the last accepted packet.
- cmd_arg  out  8  argument byte of the last accepted packet.
- trig_choice  out  3  trigger-distance index; set by command 0x01.
- manual_angle  out  8  servo angle 0–180; set by command 0x02.
- remote_manual  out  1  manual-mode request; set by command 0x03.
- frame_err  out  1  one-cycle pulse on a stop bit sampled low.
- chk_err  out  1  one-cycle pulse on a checksum mismatch.
- err_count  out  8  saturating count of frame_err plus chk_err events.

## Operation
- Reset values: cmd_valid, frame_err, chk_err = 0; cmd_id, cmd_arg = 0; trig_choice = 0; manual_angle = 90; remote_manual = 0; err_count = 0; both FSMs idle; synchroniser flops = 1.
- Byte FSM states and transitions:
  - IDLE → START on a synchronised falling edge.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If the line is high, treat as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first.
  - STOP: sample once more. If high, pulse byte_valid and return to IDLE. If low, pulse frame_err and go to WAIT_HIGH.
  - WAIT_HIGH → IDLE once the line returns high.
- Packet FSM states and transitions:
  - P_HDR: discards bytes silently until header 0xA5 arrives, then → P_CMD.
  - P_CMD → P_ARG → P_CHK, capturing one byte in each.
  - P_CHK: the checksum byte must equal (0xA5 + cmd + arg) mod 256.
  - Match: pulse cmd_valid, update cmd_id and cmd_arg, apply the decoded effect, return to P_HDR.
  - Mismatch: pulse chk_err, change no outputs, return to P_HDR.
- Decoded effects:
  - 0x01: trig_choice = arg[2:0].
  - 0x02: manual_angle = min(arg, 180).
  - 0x03: remote_manual = arg[0].
  - Any other id: cmd_valid still pulses and cmd_id/cmd_arg update; no decoded register changes.
- A frame_err in any state other than P_HDR aborts the packet; the parser returns to P_HDR.
- Inter-byte timeout: in P_CMD, P_ARG or P_CHK, if no byte_valid arrives for TIMEOUT_BITS*CLKS_PER_BIT cycles, return to P_HDR silently. A timeout is not counted as an error.
- err_count saturates at 255. If frame_err and chk_err occur in the same cycle, the count increments by 2, still saturating.
- If reset asserts mid-byte or mid-packet, all state returns to reset values immediately. After reset release, a partial frame already on the line resynchronises on the next header.

## Timing
- Synchroniser latency: 2 cycles.
- byte_valid pulses 1 cycle after the stop-bit sample.
- cmd_valid, and the decoded register updates, occur 1 cycle after the checksum byte's byte_valid.
- All outputs are registered; there are no combinational paths from uart_rx_pin.
- Back-to-back packets with zero idle time between stop and start bits are fully supported.

## Configuration
- UART_RX_CHECKSUM_EN defined: 4-byte packet (0xA5, cmd, arg, chk) with checksum verification; chk_err is live.
- UART_RX_CHECKSUM_EN undefined: 3-byte packet (0xA5, cmd, arg). P_CHK is removed and cmd_valid follows the arg byte by 1 cycle. chk_err is tied to 0.

## Structure
- Package uart_pkg holds:
  - UART_HDR = 8'hA5;
  - CMD_TRIG = 8'h01, CMD_ANGLE = 8'h02, CMD_MANUAL = 8'h03;
  - ANGLE_MAX = 180, ANGLE_RESET = 90;
  - the byte and packet FSM state typedefs.
- Sub-module uart_byte_rx contains the synchroniser, the byte FSM, the bit counter and the shift register. It outputs byte_valid, byte_data and frame_err.
- The top of this block contains the packet FSM, the timeout counter, command decode and the error counter.

## Test plan
- Send A5 01 05 AB at 115200 baud → one cmd_valid pulse; trig_choice = 5; cmd_id = 01; cmd_arg = 05; err_count = 0.
- Send A5 02 C8 6F (arg 200) → manual_angle = 180, not 200.
- Send A5 03 01 AA → chk_err pulse; remote_manual stays 0; err_count = 1. Then send A5 03 01 A9 → remote_manual = 1.
- Send byte 0x3C with its stop bit forced low → frame_err pulse. The following A5 01 02 A8 is still accepted: trig_choice = 2.
- Send A5 01, then idle 41 bit times, then 03 A9 → no cmd_valid; the parser is back in P_HDR.
- Assert reset_n low for 3 cycles mid-arg-byte → all outputs at reset values (manual_angle = 90). A subsequent full packet decodes normally.

Source files
------------

// File: rtl/uart_packet_rx_pkg.sv
// uart_pkg: shared constants, FSM state types and small helpers for the
// UART command-packet receiver.
// Build option: UART_RX_CHECKSUM_EN adds the trailing checksum byte (P_CHK).
package uart_pkg;

    localparam logic [7:0] UART_HDR    = 8'hA5;
    localparam logic [7:0] CMD_TRIG    = 8'h01;
    localparam logic [7:0] CMD_ANGLE   = 8'h02;
    localparam logic [7:0] CMD_MANUAL  = 8'h03;
    localparam logic [7:0] ANGLE_MAX   = 8'd180;
    localparam logic [7:0] ANGLE_RESET = 8'd90;

    // Per-byte receiver states.
    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_WAIT_HIGH
    } byte_state_t;

    // Packet parser states; the checksum stage only exists when enabled.
    typedef enum logic [1:0] {
        P_HDR,
        P_CMD,
        P_ARG
`ifdef UART_RX_CHECKSUM_EN
        , P_CHK
`endif
    } pkt_state_t;

`ifdef UART_RX_CHECKSUM_EN
    // Expected checksum: byte-wide sum of header, command and argument.
    function automatic logic [7:0] pkt_sum(input logic [7:0] cmd, input logic [7:0] arg);
        return UART_HDR + cmd + arg;
    endfunction
`endif

    // Servo angle is limited to the mechanical range.
    function automatic logic [7:0] clamp_angle(input logic [7:0] a);
        return (a > ANGLE_MAX) ? ANGLE_MAX : a;
    endfunction

endpackage

// File: rtl/uart_packet_rx_if.sv
// uart_packet_rx_if: serial input plus decoded command/status outputs.
// master = receiver side, slave = consumer / line driver side.
interface uart_packet_rx_if;

    logic       uart_rx_pin;
    logic       cmd_valid;
    logic [7:0] cmd_id;
    logic [7:0] cmd_arg;
    logic [2:0] trig_choice;
    logic [7:0] manual_angle;
    logic       remote_manual;
    logic       frame_err;
    logic       chk_err;
    logic [7:0] err_count;

    modport master (
        input  uart_rx_pin,
        output cmd_valid, cmd_id, cmd_arg, trig_choice, manual_angle,
               remote_manual, frame_err, chk_err, err_count
    );

    modport slave (
        output uart_rx_pin,
        input  cmd_valid, cmd_id, cmd_arg, trig_choice, manual_angle,
               remote_manual, frame_err, chk_err, err_count
    );

endinterface

// File: rtl/uart_packet_rx_byte.sv
// uart_byte_rx: 2-FF synchroniser, 8N1 byte FSM, bit counter and shift
// register. Emits registered byte_valid / frame_err pulses.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_pin,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int              HALF    = CLKS_PER_BIT / 2;
    localparam int              CW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          sync1, sync2, rx_d;
    byte_state_t   state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          fall, tick_half, tick_full;
    logic          cnt_clr, shift_en, bv_set, fe_set;

    assign fall      = rx_d & ~sync2;
    assign tick_half = (cnt == HALF_M1);
    assign tick_full = (cnt == FULL_M1);

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx_pin;
            sync2 <= sync1;
            rx_d  <= sync2;
        end
    end

    // Byte FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= B_IDLE;
        else          state <= state_nxt;
    end

    // Byte FSM next-state: mid-start check, 8 data samples, stop check.
    always_comb begin
        state_nxt = state;
        unique case (state)
            B_IDLE:      if (fall)      state_nxt = B_START;
            B_START:     if (tick_half) state_nxt = sync2 ? B_IDLE : B_DATA;
            B_DATA:      if (tick_full && bit_idx == 3'd7) state_nxt = B_STOP;
            B_STOP:      if (tick_full) state_nxt = sync2 ? B_IDLE : B_WAIT_HIGH;
            B_WAIT_HIGH: if (sync2)     state_nxt = B_IDLE;
            default:                    state_nxt = B_IDLE;
        endcase
    end

    // Byte FSM outputs: counter restart, shift strobe, result pulses.
    always_comb begin
        cnt_clr  = (state_nxt != state) || (state == B_IDLE) ||
                   (state == B_DATA && tick_full);
        shift_en = (state == B_DATA) && tick_full;
        bv_set   = (state == B_STOP) && tick_full &&  sync2;
        fe_set   = (state == B_STOP) && tick_full && !sync2;
    end

    // Bit timer, bit index, LSB-first shift register and result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cnt        <= cnt_clr ? '0 : cnt + 1'b1;
            if (state != B_DATA) bit_idx <= '0;
            else if (shift_en)   bit_idx <= bit_idx + 1'b1;
            if (shift_en) shreg <= {sync2, shreg[7:1]};
            byte_valid <= bv_set;
            frame_err  <= fe_set;
        end
    end

    // Shift register holds still outside DATA, so it doubles as the output.
    assign byte_data = shreg;

endmodule

// File: rtl/uart_packet_rx.sv
// uart_packet_rx: host command receiver. Packet FSM, inter-byte timeout,
// command decode and saturating error counter around uart_byte_rx.
// Build option: UART_RX_CHECKSUM_EN -> 4-byte packets with checksum check;
// otherwise 3-byte packets and chk_err tied low.
module uart_packet_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115_200,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_packet_rx_if.master   bus
);

    localparam int            CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int            TMO_CYC      = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int            TW           = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_M1       = TW'(TMO_CYC - 1);

    logic       byte_valid, frame_err_w, chk_err_w;
    logic [7:0] byte_data;

    pkt_state_t pstate, pstate_nxt;
    logic [TW-1:0] tmo_cnt;
    logic       tmo_hit;
    logic [7:0] cmd_r;
    logic       cap_cmd, accept, reject;
    logic [7:0] acc_arg;

    logic       cmd_valid_q, remote_manual_q;
    logic [7:0] cmd_id_q, cmd_arg_q, manual_angle_q, err_q;
    logic [2:0] trig_choice_q;
    logic [8:0] err_sum;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_pin     (bus.uart_rx_pin),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err_w)
    );

    assign tmo_hit = (tmo_cnt == TMO_M1);

    // Packet FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pstate <= P_HDR;
        else          pstate <= pstate_nxt;
    end

    // Packet FSM next-state: framing errors abort, bytes advance, stall times out.
    always_comb begin
        pstate_nxt = pstate;
        if (pstate != P_HDR && frame_err_w) begin
            pstate_nxt = P_HDR;
        end else if (byte_valid) begin
            unique case (pstate)
                P_HDR: if (byte_data == UART_HDR) pstate_nxt = P_CMD;
                P_CMD: pstate_nxt = P_ARG;
`ifdef UART_RX_CHECKSUM_EN
                P_ARG: pstate_nxt = P_CHK;
                P_CHK: pstate_nxt = P_HDR;
`else
                P_ARG: pstate_nxt = P_HDR;
`endif
                default: pstate_nxt = P_HDR;
            endcase
        end else if (pstate != P_HDR && tmo_hit) begin
            pstate_nxt = P_HDR;
        end
    end

`ifdef UART_RX_CHECKSUM_EN
    logic [7:0] arg_r;
    logic       cap_arg;
    logic       chk_err_q;

    // Packet FSM outputs: capture strobes and checksum verdict.
    always_comb begin
        cap_cmd = byte_valid && (pstate == P_CMD);
        cap_arg = byte_valid && (pstate == P_ARG);
        accept  = byte_valid && (pstate == P_CHK) && (byte_data == pkt_sum(cmd_r, arg_r));
        reject  = byte_valid && (pstate == P_CHK) && (byte_data != pkt_sum(cmd_r, arg_r));
        acc_arg = arg_r;
    end

    // Argument holding register and checksum error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arg_r     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (cap_arg) arg_r <= byte_data;
            chk_err_q <= reject;
        end
    end

    assign chk_err_w = chk_err_q;
`else
    // Packet FSM outputs: the argument byte itself completes the packet.
    always_comb begin
        cap_cmd = byte_valid && (pstate == P_CMD);
        accept  = byte_valid && (pstate == P_ARG);
        reject  = 1'b0;
        acc_arg = byte_data;
    end

    assign chk_err_w = 1'b0;
`endif

    // Inter-byte timeout: runs only mid-packet, restarts on every byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          tmo_cnt <= '0;
        else if (pstate == P_HDR || byte_valid) tmo_cnt <= '0;
        else                                    tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Command byte holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     cmd_r <= '0;
        else if (cap_cmd) cmd_r <= byte_data;
    end

    // Command strobe and decoded control registers, updated on accept only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_q     <= 1'b0;
            cmd_id_q        <= '0;
            cmd_arg_q       <= '0;
            trig_choice_q   <= '0;
            manual_angle_q  <= ANGLE_RESET;
            remote_manual_q <= 1'b0;
        end else begin
            cmd_valid_q <= accept;
            if (accept) begin
                cmd_id_q  <= cmd_r;
                cmd_arg_q <= acc_arg;
                case (cmd_r)
                    CMD_TRIG:   trig_choice_q   <= acc_arg[2:0];
                    CMD_ANGLE:  manual_angle_q  <= clamp_angle(acc_arg);
                    CMD_MANUAL: remote_manual_q <= acc_arg[0];
                    default:    ;
                endcase
            end
        end
    end

    // Error events may coincide, so add both and clamp at 255.
    assign err_sum = {1'b0, err_q} + {8'd0, frame_err_w} + {8'd0, chk_err_w};

    // Saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= '0;
        else          err_q <= (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
    end

    assign bus.cmd_valid     = cmd_valid_q;
    assign bus.cmd_id        = cmd_id_q;
    assign bus.cmd_arg       = cmd_arg_q;
    assign bus.trig_choice   = trig_choice_q;
    assign bus.manual_angle  = manual_angle_q;
    assign bus.remote_manual = remote_manual_q;
    assign bus.frame_err     = frame_err_w;
    assign bus.chk_err       = chk_err_w;
    assign bus.err_count     = err_q;

endmodule
